// File: rtl/activation_pkg.sv
// Shared types and default constants for the activation layer and its lanes.
package activation_pkg;

    // Activation selected per accepted beat.
    typedef enum logic [1:0] {
        ACT_PASS  = 2'b00,
        ACT_RELU  = 2'b01,
        ACT_LEAKY = 2'b10,
        ACT_CLAMP = 2'b11
    } act_mode_e;

    // Negative slope of leaky mode is 2^-LEAKY_SHIFT_DEFAULT.
    localparam int LEAKY_SHIFT_DEFAULT = 3;

    // Upper saturation bound of clamp mode (6.0 in Q4.10-like scaling).
    localparam logic signed [15:0] CLAMP_MAX_DEFAULT = 16'sd6144;

endpackage

// File: rtl/activation_lane.sv
// Combinational single-lane activation: y = f(x, mode).
// No mode can grow the magnitude beyond the input or CLAMP_MAX, so y has the
// same width as x and needs no saturation logic beyond the clamp itself.
module activation_lane
    import activation_pkg::*;
#(
    parameter int                          WORD_SIZE   = 16,
    parameter int                          LEAKY_SHIFT = LEAKY_SHIFT_DEFAULT,
    parameter logic signed [WORD_SIZE-1:0] CLAMP_MAX   = CLAMP_MAX_DEFAULT
) (
    input  logic signed [WORD_SIZE-1:0] x,
    input  act_mode_e                   mode,
    output logic signed [WORD_SIZE-1:0] y
);

    logic is_neg;
    assign is_neg = x[WORD_SIZE-1];

    // Select the activation for this lane; leaky uses an arithmetic shift so
    // small negatives round toward -inf (e.g. -1 stays -1).
    always_comb begin
        y = x;
        unique case (mode)
            ACT_PASS:  y = x;
            ACT_RELU:  y = is_neg ? '0 : x;
            ACT_LEAKY: y = is_neg ? (x >>> LEAKY_SHIFT) : x;
            ACT_CLAMP: begin
                if (is_neg) begin
                    y = '0;
                end else if (x > CLAMP_MAX) begin
                    y = CLAMP_MAX;
                end else begin
                    y = x;
                end
            end
            default:   y = x;
        endcase
    end

endmodule

// File: rtl/activation_layer.sv
// Multi-lane activation layer on valid/ready handshakes with a 2-entry output
// buffer (head register drives data_r_o, skid register absorbs one extra beat).
// ready_o depends only on the registered occupancy, never on ready_i.
module activation_layer
    import activation_pkg::*;
#(
    parameter int                          WORD_SIZE    = 16,
    parameter int                          NUM_CHANNELS = 1,
    parameter int                          LEAKY_SHIFT  = LEAKY_SHIFT_DEFAULT,
    parameter logic signed [WORD_SIZE-1:0] CLAMP_MAX    = CLAMP_MAX_DEFAULT
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [1:0]                        mode_i,
    output logic                              ready_o,
    input  logic                              valid_i,
    input  logic [NUM_CHANNELS*WORD_SIZE-1:0] data_r_i,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic [NUM_CHANNELS*WORD_SIZE-1:0] data_r_o
);

    localparam int DW = NUM_CHANNELS * WORD_SIZE;

    logic [1:0]    count_reg;
    logic [DW-1:0] head_reg;
    logic [DW-1:0] skid_reg;
    logic [DW-1:0] act_data;
    act_mode_e     mode_sel;
    logic          push;
    logic          pop;

    assign mode_sel = act_mode_e'(mode_i);

    // One combinational activation lane per channel; lanes never interact.
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_lane
        activation_lane #(
            .WORD_SIZE   (WORD_SIZE),
            .LEAKY_SHIFT (LEAKY_SHIFT),
            .CLAMP_MAX   (CLAMP_MAX)
        ) u_lane (
            .x    (data_r_i[gi*WORD_SIZE +: WORD_SIZE]),
            .mode (mode_sel),
            .y    (act_data[gi*WORD_SIZE +: WORD_SIZE])
        );
    end

    assign ready_o  = (count_reg != 2'd2);
    assign valid_o  = (count_reg != 2'd0);
    assign data_r_o = head_reg;
    assign push     = valid_i & ready_o;
    assign pop      = valid_o & ready_i;

    // Buffer occupancy and data movement; the head keeps its stale value when
    // drained so data_r_o only changes when a new beat lands in it.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_reg <= 2'd0;
            head_reg  <= '0;
            skid_reg  <= '0;
        end else begin
            case (count_reg)
                2'd0: begin
                    if (push) begin
                        head_reg  <= act_data;
                        count_reg <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_reg <= act_data;
                    end else if (push) begin
                        skid_reg  <= act_data;
                        count_reg <= 2'd2;
                    end else if (pop) begin
                        count_reg <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head_reg  <= skid_reg;
                        count_reg <= 2'd1;
                    end
                end
                default: count_reg <= 2'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_activation_layer.sv
// Directed bench for activation_layer with four 16-bit lanes.
module tb_activation_layer;

    localparam int W  = 16;
    localparam int NC = 4;
    localparam int DW = W * NC;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [1:0]    mode_i;
    logic          ready_o;
    logic          valid_i;
    logic [DW-1:0] data_r_i;
    logic          valid_o;
    logic          ready_i;
    logic [DW-1:0] data_r_o;

    int checks = 0;
    int errors = 0;

    activation_layer #(
        .WORD_SIZE    (W),
        .NUM_CHANNELS (NC),
        .LEAKY_SHIFT  (3),
        .CLAMP_MAX    (16'sd6144)
    ) dut (
        .clk_i    (clk),
        .reset_i  (reset_i),
        .mode_i   (mode_i),
        .ready_o  (ready_o),
        .valid_i  (valid_i),
        .data_r_i (data_r_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .data_r_o (data_r_o)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rep(input logic [W-1:0] v);
        return {NC{v}};
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive inputs just after the active edge.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [1:0] m, input logic r);
        valid_i  = v;
        data_r_i = d;
        mode_i   = m;
        ready_i  = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream four beats with ready_i=1; each result appears one cycle later.
    task automatic stream(input string tag, input logic [1:0] m,
                          input logic [4*W-1:0] xs, input logic [4*W-1:0] ys);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, rep(xs[i*W +: W]), m, 1'b1);
            @(negedge clk);
            chk($sformatf("%s_ready%0d", tag, i), DW'(ready_o), DW'(1));
            tick();
            chk($sformatf("%s_valid%0d", tag, i), DW'(valid_o), DW'(1));
            chk($sformatf("%s_data%0d", tag, i), data_r_o, rep(ys[i*W +: W]));
            $display("%s beat %0d: in %0d out %0d", tag, i,
                     $signed(xs[i*W +: W]), $signed(data_r_o[W-1:0]));
        end
        drive(1'b0, '0, m, 1'b1);
        tick();
        chk({tag, "_drain"}, DW'(valid_o), DW'(0));
    endtask

    logic [DW-1:0] a_beat, b_beat, c_beat, vec;

    initial begin
        drive(1'b0, '0, 2'b00, 1'b0);
        reset_i = 1'b1;
        tick();
        tick();
        chk("rst_valid", DW'(valid_o), DW'(0));
        chk("rst_ready", DW'(ready_o), DW'(1));
        chk("rst_data", data_r_o, '0);
        reset_i = 1'b0;
        $display("reset: valid %0b ready %0b data %h", valid_o, ready_o, data_r_o);

        // xs/ys packed with element 0 in the low bits.
        stream("relu", 2'b01,
               {16'sd0, -16'sd32768, 16'sd7, -16'sd5},
               {16'sd0, 16'sd0, 16'sd7, 16'sd0});
        stream("leaky", 2'b10,
               {16'sd40, -16'sd9, -16'sd1, -16'sd64},
               {16'sd40, -16'sd2, -16'sd1, -16'sd8});
        stream("clamp", 2'b11,
               {16'sd100, -16'sd3, 16'sd6144, 16'sd8000},
               {16'sd100, 16'sd0, 16'sd6144, 16'sd6144});

        // Per-lane independence.
        vec = {-16'sd1, 16'sd2, -16'sd3, 16'sd4};
        drive(1'b1, vec, 2'b00, 1'b1);
        tick();
        chk("lanes_pass", data_r_o, vec);
        $display("lanes pass: out %h", data_r_o);
        drive(1'b1, vec, 2'b01, 1'b1);
        tick();
        chk("lanes_relu", data_r_o, {16'sd0, 16'sd2, 16'sd0, 16'sd4});
        $display("lanes relu: out %h", data_r_o);
        drive(1'b0, '0, 2'b00, 1'b1);
        tick();
        chk("lanes_drain", DW'(valid_o), DW'(0));

        // Backpressure: A, B accepted, C held upstream.
        a_beat = {16'sd11, 16'sd12, 16'sd13, 16'sd14};
        b_beat = {16'sd21, -16'sd22, 16'sd23, 16'sd24};
        c_beat = {-16'sd31, 16'sd32, 16'sd33, 16'sd34};
        drive(1'b1, a_beat, 2'b00, 1'b0);
        tick();
        chk("bp_a_valid", DW'(valid_o), DW'(1));
        chk("bp_a_data", data_r_o, a_beat);
        drive(1'b1, b_beat, 2'b00, 1'b0);
        tick();
        chk("bp_full_ready", DW'(ready_o), DW'(0));
        chk("bp_hold1", data_r_o, a_beat);
        drive(1'b1, c_beat, 2'b00, 1'b0);
        tick();
        chk("bp_hold2", data_r_o, a_beat);
        chk("bp_hold2_valid", DW'(valid_o), DW'(1));
        chk("bp_hold2_ready", DW'(ready_o), DW'(0));
        ready_i = 1'b1;
        @(negedge clk);
        chk("bp_ready_indep", DW'(ready_o), DW'(0));
        tick();
        chk("bp_out_b", data_r_o, b_beat);
        chk("bp_ready_back", DW'(ready_o), DW'(1));
        $display("backpressure: out B %h", data_r_o);
        tick();
        chk("bp_out_c", data_r_o, c_beat);
        chk("bp_out_c_valid", DW'(valid_o), DW'(1));
        $display("backpressure: out C %h", data_r_o);
        drive(1'b0, '0, 2'b00, 1'b1);
        tick();
        chk("bp_drain", DW'(valid_o), DW'(0));

        // Mode switch: same beat under RELU then PASS.
        drive(1'b1, rep(16'h8005), 2'b01, 1'b0);
        tick();
        drive(1'b1, rep(16'h8005), 2'b00, 1'b0);
        tick();
        chk("ms_first", data_r_o, rep(16'h0000));
        chk("ms_full", DW'(ready_o), DW'(0));
        drive(1'b0, '0, 2'b00, 1'b1);
        tick();
        chk("ms_second", data_r_o, rep(16'h8005));
        $display("mode switch: second out %h", data_r_o);
        tick();
        chk("ms_drain", DW'(valid_o), DW'(0));

        // Reset while full.
        drive(1'b1, rep(16'sd77), 2'b00, 1'b0);
        tick();
        drive(1'b1, rep(16'sd88), 2'b00, 1'b0);
        tick();
        chk("rf_full", DW'(ready_o), DW'(0));
        reset_i = 1'b1;
        drive(1'b0, '0, 2'b00, 1'b1);
        tick();
        reset_i = 1'b0;
        chk("rf_valid", DW'(valid_o), DW'(0));
        chk("rf_ready", DW'(ready_o), DW'(1));
        chk("rf_data", data_r_o, '0);
        $display("reset mid-op: valid %0b ready %0b data %h", valid_o, ready_o, data_r_o);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rf_no_stale%0d", i), DW'(valid_o), DW'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
